// File: rtl/dec_sched_pkg.sv
// Shared definitions for the decryption scheduler.
//   - Engine select codes (caesar, scytale, zigzag, none)
//   - FSM state encoding
//   - WAIT_TIMEOUT: cycles the scheduler waits for the engine to go busy
//   - eng_onehot(): maps a select code to the one-hot engine valid vector
package dec_sched_pkg;

  localparam logic [1:0] ENG_CAESAR  = 2'd0;
  localparam logic [1:0] ENG_SCYTALE = 2'd1;
  localparam logic [1:0] ENG_ZIGZAG  = 2'd2;
  localparam logic [1:0] ENG_NONE    = 2'd3;

  localparam int unsigned WAIT_TIMEOUT = 4;

  typedef enum logic [1:0] {
    StIdle,
    StFeed,
    StWait,
    StDrain
  } dec_state_e;

  // An invalid select maps to no engine at all.
  function automatic logic [2:0] eng_onehot(input logic [1:0] sel);
    logic [2:0] oh;
    oh = 3'b000;
    case (sel)
      ENG_CAESAR:  oh = 3'b001;
      ENG_SCYTALE: oh = 3'b010;
      ENG_ZIGZAG:  oh = 3'b100;
      default:     oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/dec_out_mux.sv
// Registered 3:1 selector for the engine return streams.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   en_i          accept engine output this cycle
//   sel_i         latched engine select (ENG_NONE selects nothing)
//   eng_data_i    engine outputs {zig, scy, cae}
//   eng_valid_i   per-engine output valid
//   data_o        registered selected character
//   valid_o       registered selected qualifier
module dec_out_mux
  import dec_sched_pkg::*;
#(
  parameter int unsigned D_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic [1:0]             sel_i,
  input  logic [3*D_WIDTH-1:0]   eng_data_i,
  input  logic [2:0]             eng_valid_i,
  output logic [D_WIDTH-1:0]     data_o,
  output logic                   valid_o
);

  logic [D_WIDTH-1:0] sel_data;
  logic               sel_valid;
  logic [D_WIDTH-1:0] data_q;
  logic               valid_q;

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    case (sel_i)
      ENG_CAESAR: begin
        sel_data  = eng_data_i[0*D_WIDTH +: D_WIDTH];
        sel_valid = eng_valid_i[0];
      end
      ENG_SCYTALE: begin
        sel_data  = eng_data_i[1*D_WIDTH +: D_WIDTH];
        sel_valid = eng_valid_i[1];
      end
      ENG_ZIGZAG: begin
        sel_data  = eng_data_i[2*D_WIDTH +: D_WIDTH];
        sel_valid = eng_valid_i[2];
      end
      default: begin
        sel_data  = '0;
        sel_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= en_i & sel_valid;
      if (en_i && sel_valid) begin
        data_q <= sel_data;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/decryption_scheduler.sv
// Front-end sequencer for the caesar / scytale / zigzag decryption engines.
// Latches select and key on the first character of a message, forwards characters
// (token included) to the selected engine, holds off upstream while the engine
// drains, and registers the selected engine's output onto data_o/valid_o.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   data_i, valid_i               upstream character stream
//   sel_i, key_i                  engine select / key, sampled on the first char
//   busy_o                        upstream must not drive valid_i
//   eng_data_o/valid_o/key_o      forward bus to the engines (valid is one-hot)
//   eng_busy_i/data_i/valid_i     engine status and output streams {zig,scy,cae}
//   data_o, valid_o               decrypted stream
//   err_o                         one-cycle protocol error pulse
// Optional: define DEC_SCHED_STATS_EN to add msg_cnt_o (per-engine completed
// messages, wrapping) and err_cnt_o (error pulses, saturating).
module decryption_scheduler
  import dec_sched_pkg::*;
#(
  parameter int unsigned         D_WIDTH                = 8,
  parameter int unsigned         KEY_WIDTH              = 16,
  parameter int unsigned         MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0]  START_DECRYPTION_TOKEN = 8'hFA
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [D_WIDTH-1:0]     data_i,
  input  logic                   valid_i,
  input  logic [1:0]             sel_i,
  input  logic [KEY_WIDTH-1:0]   key_i,
  output logic                   busy_o,
  output logic [D_WIDTH-1:0]     eng_data_o,
  output logic [2:0]             eng_valid_o,
  output logic [KEY_WIDTH-1:0]   eng_key_o,
  input  logic [2:0]             eng_busy_i,
  input  logic [3*D_WIDTH-1:0]   eng_data_i,
  input  logic [2:0]             eng_valid_i,
  output logic [D_WIDTH-1:0]     data_o,
  output logic                   valid_o,
`ifdef DEC_SCHED_STATS_EN
  output logic [3*8-1:0]         msg_cnt_o,
  output logic [7:0]             err_cnt_o,
`endif
  output logic                   err_o
);

  localparam int unsigned CntW  = $clog2(MAX_NOF_CHARS + 1);
  localparam int unsigned WaitW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CntW-1:0]  MaxCnt  = CntW'(MAX_NOF_CHARS);
  localparam logic [WaitW-1:0] WaitEnd = WaitW'(WAIT_TIMEOUT - 1);

  dec_state_e           state_q, state_d;
  logic [1:0]           sel_q, sel_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [WaitW-1:0]     wait_q, wait_d;
  logic [D_WIDTH-1:0]   fwd_data_q, fwd_data_d;
  logic [2:0]           fwd_valid_q, fwd_valid_d;
  logic                 err_q, err_d;
  logic                 is_tok;
  logic                 sel_busy;
  logic                 drain_done;

  assign is_tok = (data_i == START_DECRYPTION_TOKEN);

  // Busy of the latched engine; an invalid select has no engine to watch.
  always_comb begin
    sel_busy = 1'b0;
    case (sel_q)
      ENG_CAESAR:  sel_busy = eng_busy_i[0];
      ENG_SCYTALE: sel_busy = eng_busy_i[1];
      ENG_ZIGZAG:  sel_busy = eng_busy_i[2];
      default:     sel_busy = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    key_d       = key_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    fwd_data_d  = fwd_data_q;
    fwd_valid_d = 3'b000;
    err_d       = 1'b0;
    drain_done  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (valid_i) begin
          if (is_tok) begin
            err_d = 1'b1;
          end else begin
            sel_d       = sel_i;
            key_d       = key_i;
            cnt_d       = CntW'(1);
            state_d     = StFeed;
            fwd_valid_d = eng_onehot(sel_i);
            if (sel_i != ENG_NONE) fwd_data_d = data_i;
          end
        end
      end

      StFeed: begin
        if (valid_i) begin
          if (is_tok) begin
            if (sel_q == ENG_NONE) begin
              // Invalid select: the message was swallowed, report it at the end.
              err_d   = 1'b1;
              state_d = StIdle;
            end else begin
              fwd_valid_d = eng_onehot(sel_q);
              fwd_data_d  = data_i;
              wait_d      = '0;
              state_d     = StWait;
            end
          end else if (cnt_q == MaxCnt) begin
            err_d = 1'b1;
          end else begin
            cnt_d       = cnt_q + CntW'(1);
            fwd_valid_d = eng_onehot(sel_q);
            if (sel_q != ENG_NONE) fwd_data_d = data_i;
          end
        end
      end

      StWait: begin
        if (valid_i) err_d = 1'b1;
        if (sel_busy) begin
          state_d = StDrain;
        end else if (wait_q == WaitEnd) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end

      StDrain: begin
        if (valid_i) err_d = 1'b1;
        // Entered with busy high, so a low busy here is the falling edge.
        if (!sel_busy) begin
          state_d    = StIdle;
          drain_done = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sel_q       <= 2'd0;
      key_q       <= '0;
      cnt_q       <= '0;
      wait_q      <= '0;
      fwd_data_q  <= '0;
      fwd_valid_q <= 3'b000;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      key_q       <= key_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      fwd_data_q  <= fwd_data_d;
      fwd_valid_q <= fwd_valid_d;
      err_q       <= err_d;
    end
  end

  assign busy_o      = (state_q == StWait) || (state_q == StDrain);
  assign eng_data_o  = fwd_data_q;
  assign eng_valid_o = fwd_valid_q;
  assign eng_key_o   = key_q;
  assign err_o       = err_q;

  dec_out_mux #(
    .D_WIDTH (D_WIDTH)
  ) u_out_mux (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (busy_o),
    .sel_i       (sel_q),
    .eng_data_i  (eng_data_i),
    .eng_valid_i (eng_valid_i),
    .data_o      (data_o),
    .valid_o     (valid_o)
  );

`ifdef DEC_SCHED_STATS_EN
  logic [2:0][7:0] msg_cnt_q;
  logic [7:0]      err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (drain_done && (sel_q == 2'(i))) msg_cnt_q[i] <= msg_cnt_q[i] + 8'd1;
      end
      if (err_q && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign msg_cnt_o = msg_cnt_q;
  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_decryption_scheduler.sv
module tb_decryption_scheduler;

  localparam logic [7:0] TOK = 8'hFA;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data_i;
  logic        valid_i;
  logic [1:0]  sel_i;
  logic [15:0] key_i;
  logic        busy_o;
  logic [7:0]  eng_data_o;
  logic [2:0]  eng_valid_o;
  logic [15:0] eng_key_o;
  logic [2:0]  eng_busy_i;
  logic [23:0] eng_data_i;
  logic [2:0]  eng_valid_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        err_o;

  int n_cmp = 0;
  int n_bad = 0;
  int err_seen = 0;
  int fwd0 = 0, fwd1 = 0, fwd2 = 0;
  int e_base, f0_base, f1_base, f2_base;
  string msg;

  decryption_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .sel_i       (sel_i),
    .key_i       (key_i),
    .busy_o      (busy_o),
    .eng_data_o  (eng_data_o),
    .eng_valid_o (eng_valid_o),
    .eng_key_o   (eng_key_o),
    .eng_busy_i  (eng_busy_i),
    .eng_data_i  (eng_data_i),
    .eng_valid_i (eng_valid_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle tallies of error pulses and forwarded characters per engine.
  always @(negedge clk) begin
    if (rst_n) begin
      err_seen += int'(err_o);
      fwd0 += int'(eng_valid_o[0]);
      fwd1 += int'(eng_valid_o[1]);
      fwd2 += int'(eng_valid_o[2]);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic [15:0] k, input logic [7:0] d);
    sel_i   = s;
    key_i   = k;
    data_i  = d;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic snap();
    settle();
    e_base  = err_seen;
    f0_base = fwd0;
    f1_base = fwd1;
    f2_base = fwd2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy_o"},      32'(busy_o),      32'd0);
    chk({tag, " eng_valid_o"}, 32'(eng_valid_o), 32'd0);
    chk({tag, " eng_data_o"},  32'(eng_data_o),  32'd0);
    chk({tag, " eng_key_o"},   32'(eng_key_o),   32'd0);
    chk({tag, " data_o"},      32'(data_o),      32'd0);
    chk({tag, " valid_o"},     32'(valid_o),     32'd0);
    chk({tag, " err_o"},       32'(err_o),       32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    data_i      = '0;
    valid_i     = 1'b0;
    sel_i       = '0;
    key_i       = '0;
    eng_busy_i  = '0;
    eng_data_i  = '0;
    eng_valid_i = '0;
    tick();
    tick();
    chk_all_zero("reset");
    settle();
    rst_n = 1'b1;

    // T1: caesar "KHOOR" + token, engine answers "HELLO".
    snap();
    msg = "KHOOR";
    for (int i = 0; i < 5; i++) begin
      send(2'd0, 16'd3, msg[i]);
      chk("t1 eng_valid_o", 32'(eng_valid_o), 32'h1);
      chk("t1 eng_data_o", 32'(eng_data_o), 32'(msg[i]));
    end
    chk("t1 eng_key_o", 32'(eng_key_o), 32'd3);
    chk("t1 busy before token", 32'(busy_o), 32'd0);
    send(2'd0, 16'd3, TOK);
    chk("t1 token valid", 32'(eng_valid_o), 32'h1);
    chk("t1 token data", 32'(eng_data_o), 32'hFA);
    chk("t1 busy after token", 32'(busy_o), 32'd1);
    tick();
    eng_busy_i = 3'b001;
    tick();
    msg = "HELLO";
    for (int i = 0; i < 5; i++) begin
      eng_data_i  = {8'h99, 8'h88, msg[i]};
      eng_valid_i = 3'b011;
      if (i == 4) eng_busy_i = 3'b000;
      tick();
      chk("t1 valid_o", 32'(valid_o), 32'd1);
      chk("t1 data_o", 32'(data_o), 32'(msg[i]));
    end
    eng_valid_i = 3'b000;
    chk("t1 busy_o dropped", 32'(busy_o), 32'd0);
    tick();
    chk("t1 valid_o idle", 32'(valid_o), 32'd0);
    settle();
    chk("t1 fwd caesar", 32'(fwd0 - f0_base), 32'd6);
    chk("t1 fwd others", 32'(fwd1 + fwd2 - f1_base - f2_base), 32'd0);
    chk("t1 err count", 32'(err_seen - e_base), 32'd0);

    // T2: zigzag routing.
    snap();
    for (int i = 0; i < 10; i++) begin
      send(2'd2, 16'd3, 8'h30 + 8'(i));
      chk("t2 eng_valid_o", 32'(eng_valid_o), 32'h4);
      chk("t2 eng_key_o", 32'(eng_key_o), 32'd3);
    end
    send(2'd2, 16'd3, TOK);
    chk("t2 token valid", 32'(eng_valid_o), 32'h4);
    eng_busy_i = 3'b100;
    tick();
    eng_data_i  = {8'h5A, 8'h11, 8'h22};
    eng_valid_i = 3'b111;
    tick();
    chk("t2 data_o zig", 32'(data_o), 32'h5A);
    chk("t2 valid_o zig", 32'(valid_o), 32'd1);
    eng_data_i  = {8'h6B, 8'h33, 8'h44};
    eng_valid_i = 3'b011;
    tick();
    chk("t2 valid_o others ignored", 32'(valid_o), 32'd0);
    chk("t2 data_o held", 32'(data_o), 32'h5A);
    chk("t2 key held", 32'(eng_key_o), 32'd3);
    eng_valid_i = 3'b000;
    eng_busy_i  = 3'b000;
    tick();
    chk("t2 busy_o dropped", 32'(busy_o), 32'd0);
    settle();
    chk("t2 fwd zigzag", 32'(fwd2 - f2_base), 32'd11);
    chk("t2 fwd others", 32'(fwd0 + fwd1 - f0_base - f1_base), 32'd0);

    // T3: overflow, MAX_NOF_CHARS + 2 characters.
    snap();
    for (int i = 0; i < 52; i++) begin
      send(2'd0, 16'd1, 8'(i + 1));
      if (i >= 50) begin
        chk("t3 overflow err", 32'(err_o), 32'd1);
        chk("t3 overflow dropped", 32'(eng_valid_o), 32'd0);
      end
    end
    send(2'd0, 16'd1, TOK);
    chk("t3 token fwd", 32'(eng_valid_o), 32'h1);
    settle();
    chk("t3 fwd count", 32'(fwd0 - f0_base), 32'd51);
    chk("t3 err count", 32'(err_seen - e_base), 32'd2);
    eng_busy_i = 3'b001;
    tick();
    eng_busy_i = 3'b000;
    tick();
    chk("t3 back idle", 32'(busy_o), 32'd0);

    // T4: protocol errors.
    snap();
    send(2'd1, 16'd7, "A");
    send(2'd1, 16'd7, TOK);
    eng_busy_i = 3'b010;
    tick();
    send(2'd0, 16'd0, "Z");
    chk("t4 drain err", 32'(err_o), 32'd1);
    chk("t4 drain not fwd", 32'(eng_valid_o), 32'd0);
    chk("t4 drain still busy", 32'(busy_o), 32'd1);
    eng_busy_i = 3'b000;
    tick();
    chk("t4 drain done", 32'(busy_o), 32'd0);
    send(2'd3, 16'd0, "X");
    chk("t4 sel3 not fwd", 32'(eng_valid_o), 32'd0);
    chk("t4 sel3 no err", 32'(err_o), 32'd0);
    send(2'd3, 16'd0, "Y");
    chk("t4 sel3 not fwd 2", 32'(eng_valid_o), 32'd0);
    send(2'd3, 16'd0, TOK);
    chk("t4 sel3 token err", 32'(err_o), 32'd1);
    chk("t4 sel3 token not fwd", 32'(eng_valid_o), 32'd0);
    chk("t4 sel3 never busy", 32'(busy_o), 32'd0);
    send(2'd0, 16'd0, TOK);
    chk("t4 lone token err", 32'(err_o), 32'd1);
    chk("t4 lone token not fwd", 32'(eng_valid_o), 32'd0);
    tick();
    settle();
    chk("t4 err count", 32'(err_seen - e_base), 32'd3);
    chk("t4 fwd count", 32'(fwd0 + fwd1 + fwd2 - f0_base - f1_base - f2_base), 32'd2);

    // T5: timeout in WAIT.
    send(2'd0, 16'd9, "Q");
    send(2'd0, 16'd9, TOK);
    chk("t5 wait busy", 32'(busy_o), 32'd1);
    chk("t5 wait no err", 32'(err_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5 no early err", 32'(err_o), 32'd0);
      chk("t5 still busy", 32'(busy_o), 32'd1);
    end
    tick();
    chk("t5 timeout err", 32'(err_o), 32'd1);
    chk("t5 timeout idle", 32'(busy_o), 32'd0);
    tick();
    chk("t5 err one cycle", 32'(err_o), 32'd0);

    // T6: reset mid-DRAIN, then a scytale message.
    send(2'd2, 16'd4, "M");
    send(2'd2, 16'd4, TOK);
    eng_busy_i = 3'b100;
    tick();
    eng_data_i  = {8'h77, 8'h00, 8'h00};
    eng_valid_i = 3'b100;
    tick();
    chk("t6 pre-reset valid_o", 32'(valid_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6 reset");
    eng_busy_i  = '0;
    eng_valid_i = '0;
    eng_data_i  = '0;
    @(posedge clk);
    settle();
    rst_n = 1'b1;
    send(2'd1, 16'd5, "S");
    chk("t6 scy valid", 32'(eng_valid_o), 32'h2);
    chk("t6 scy key", 32'(eng_key_o), 32'd5);
    send(2'd1, 16'd5, TOK);
    chk("t6 scy token", 32'(eng_valid_o), 32'h2);
    eng_busy_i = 3'b010;
    tick();
    eng_data_i  = {8'hEE, 8'h33, 8'hDD};
    eng_valid_i = 3'b111;
    tick();
    chk("t6 scy data_o", 32'(data_o), 32'h33);
    eng_valid_i = 3'b000;
    eng_busy_i  = 3'b000;
    tick();
    chk("t6 scy done", 32'(busy_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
